// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle for serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder, LSB first, one bit per clock through a single full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    serial_add_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Full adder as two half adders plus an OR
    logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;
    always_comb begin
        ha1_s = a_q[0] ^ b_q[0];
        ha1_c = a_q[0] & b_q[0];
        fa_s  = ha1_s ^ carry_q;
        ha2_c = ha1_s & carry_q;
        fa_c  = ha1_c | ha2_c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                // Counter stops on the last bit so it never wraps
                if (cnt_q == LastBit) begin
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl at WIDTH=8; ovf is checked when
// SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid after the accept edge; returns edges counted (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADD_OVF_EN
        check(tag, {31'd0, bus.ovf}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("ovf %s unused", tag);
`endif
    endtask

    task automatic run_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        check({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        tick();
        bus.in_valid = 1'b0;
        wait_done(lat);
        check({tag, "_lat"}, lat, W);
        check({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
        check_ovf({tag, "_ovf"}, eo);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int pulses;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        #3;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_sum", {24'd0, bus.sum}, 32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_add("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_add("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_add("7f_01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_add("80_80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

        // Back-pressure: result must hold while out_ready stays low
        bus.in_valid = 1'b1;
        bus.a        = 8'hA5;
        bus.b        = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        wait_done(lat);
        check("bp_lat", lat, W);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_sum", {24'd0, bus.sum}, 32'hFF);
            check("bp_cout", {31'd0, bus.cout}, 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_idle", {31'd0, bus.in_ready}, 32'd1);
        check("bp_valid_off", {31'd0, bus.out_valid}, 32'd0);

        // Operand churn during RUN must be ignored
        bus.in_valid = 1'b1;
        bus.a        = 8'h11;
        bus.b        = 8'h22;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("churn_ready", {31'd0, bus.in_ready}, 32'd0);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            tick();
        end
        check("churn_valid", {31'd0, bus.out_valid}, 32'd1);
        check("churn_sum", {24'd0, bus.sum}, 32'h33);
        check("churn_cout", {31'd0, bus.cout}, 32'd0);
        bus.a         = 8'h10;
        bus.b         = 8'h20;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("churn_no_accept", {31'd0, bus.in_ready}, 32'd1);
        check("churn_busy_off", {31'd0, bus.busy}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("churn_accept", {31'd0, bus.busy}, 32'd1);
        wait_done(lat);
        check("churn2_lat", lat, W);
        check("churn2_sum", {24'd0, bus.sum}, 32'h30);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset mid-operation aborts with no later out_valid
        bus.in_valid = 1'b1;
        bus.a        = 8'hF0;
        bus.b        = 8'h0F;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_sum", {24'd0, bus.sum}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid === 1'b1) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        run_add("post_abort", 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the operands, unsigned.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the result, (a+b) mod 2^WIDTH.
REQ-010 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.
REQ-011 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-012 The block SHALL compute the sum bit-serially, LSB first, one bit per clock, through one shared 1-bit adder cell.
REQ-013 The adder cell SHALL be two half adders plus an OR: s = a_i^b_i^c, c' = a_i&b_i | c&(a_i^b_i).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL equal 1 only in IDLE.
REQ-016 On an edge in IDLE with in_valid=1, the block SHALL capture a and b into shift registers, clear the carry register and bit counter, and enter RUN.
REQ-017 In RUN, each edge SHALL process one bit: the sum bit shifts into sum[WIDTH-1], the operand registers shift right, the carry updates, and the counter increments.
REQ-018 On the edge that processes bit WIDTH-1, the block SHALL set cout from the final carry and enter DONE.
REQ-019 out_valid SHALL be high exactly in DONE, first asserting WIDTH edges after the accept edge.
REQ-020 sum and cout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 On an edge in DONE with out_ready=1, the block SHALL return to IDLE.
REQ-022 No new operands SHALL be accepted on the same edge that leaves DONE; the minimum issue interval is WIDTH+2 cycles.
REQ-023 Changes on in_valid, a or b outside IDLE SHALL be ignored; operands are sampled only at acceptance.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap while in RUN.

Reset
REQ-025 While rst_n=0, the block SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, all internal registers 0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no output pulse after release.
REQ-027 The block SHALL leave reset on the first clk edge after rst_n rises, in IDLE.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN SHALL control a signed-overflow output.
REQ-029 With SERIAL_ADD_OVF_EN defined, the block SHALL add output port ovf, 1 bit, registered with cout: ovf = (carry into bit WIDTH-1) XOR (cout), valid while out_valid=1, reset value 0.
REQ-030 Without SERIAL_ADD_OVF_EN, neither the ovf port nor its logic SHALL exist; all other behaviour is identical.

Verification (WIDTH=8, SERIAL_ADD_OVF_EN defined unless noted)
REQ-031 Test: a=0x00, b=0x00 -> after 8 edges, out_valid=1, sum=0x00, cout=0, ovf=0.
REQ-032 Test: a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0; and a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-033 Test: a=0xA5, b=0x5A with out_ready held 0 for 5 cycles after out_valid -> sum=0xFF and cout=0 stay stable; IDLE is entered one edge after out_ready=1.
REQ-034 Test: in_valid=1 with new operands throughout RUN -> in_ready=0, the result is unaffected, and the next operands are accepted only after the return to IDLE.
REQ-035 Test: rst_n pulsed low at bit 4 of a=0xF0 + b=0x0F -> immediate in_ready=1 and out_valid=0; no out_valid afterwards; a new add of 0x03+0x04 gives 0x07.
REQ-036 Test: build without SERIAL_ADD_OVF_EN, a=0x80, b=0x80 -> sum=0x00, cout=1; ovf port absent.
